// File: rtl/sad_min_search.sv
// Sequences a SAD unit over n candidates and keeps the minimum SAD and its index.
// Per candidate: LAUNCH, WAIT (at least 1 cycle), SETTLE, CAPTURE. One DONE cycle closes the search.
module sad_min_search #(
  parameter int IDX_W = 6,
  parameter int SAD_W = 16
) (
  input  logic             clk,
  input  logic             rstn_i,
  input  logic             start_i,
  input  logic [IDX_W-1:0] n_cand_i,
  input  logic             sad_busy_i,
  input  logic [SAD_W-1:0] sad_i,
  output logic             sad_enb_o,
  output logic [IDX_W-1:0] cand_idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [SAD_W-1:0] best_sad_o,
  output logic [IDX_W-1:0] best_idx_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LAUNCH  = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_SETTLE  = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]       state;
  logic [IDX_W-1:0] count_q;
  logic [IDX_W-1:0] cand_idx_q;
  logic [IDX_W-1:0] min_idx_q;
  logic [SAD_W-1:0] min_sad_q;
  logic             min_vld_q;
  logic [SAD_W-1:0] best_sad_q;
  logic [IDX_W-1:0] best_idx_q;
  logic             last_cand;
  logic             take_sad;

  // A latched count of 0 means 2^IDX_W, so count-1 wraps to all ones and the index never wraps.
  assign last_cand = (cand_idx_q == (count_q - IDX_W'(1)));
  assign take_sad  = !min_vld_q || (sad_i < min_sad_q);

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= S_IDLE;
      count_q    <= '0;
      cand_idx_q <= '0;
      min_idx_q  <= '0;
      min_sad_q  <= '0;
      min_vld_q  <= 1'b0;
      best_sad_q <= '0;
      best_idx_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            count_q    <= n_cand_i;
            cand_idx_q <= '0;
            min_vld_q  <= 1'b0;
            state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: state <= S_WAIT;
        S_WAIT: begin
          if (!sad_busy_i) state <= S_SETTLE;
        end
        S_SETTLE: state <= S_CAPTURE;
        S_CAPTURE: begin
          if (take_sad) begin
            min_sad_q <= sad_i;
            min_idx_q <= cand_idx_q;
            min_vld_q <= 1'b1;
          end
          if (last_cand) begin
            state <= S_DONE;
          end else begin
            cand_idx_q <= cand_idx_q + IDX_W'(1);
            state      <= S_LAUNCH;
          end
        end
        S_DONE: begin
          best_sad_q <= min_sad_q;
          best_idx_q <= min_idx_q;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign sad_enb_o  = (state == S_LAUNCH);
  assign done_o     = (state == S_DONE);
  assign busy_o     = (state == S_LAUNCH) || (state == S_WAIT) ||
                      (state == S_SETTLE) || (state == S_CAPTURE);
  assign cand_idx_o = cand_idx_q;
  assign best_sad_o = best_sad_q;
  assign best_idx_o = best_idx_q;

endmodule

// File: tb/tb_sad_min_search.sv
// Directed bench for sad_min_search with a behavioural SAD unit and a result scoreboard.
module tb_sad_min_search;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [5:0]  n_cand;
  logic        sad_busy;
  logic [15:0] sad;
  logic        sad_enb_o;
  logic [5:0]  cand_idx_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] best_sad_o;
  logic [5:0]  best_idx_o;

  typedef struct {
    logic [15:0] sad;
    logic [5:0]  idx;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] tbl[64];
  int          lat;
  int          errors = 0;
  int          checks = 0;

  sad_min_search #(.IDX_W(6), .SAD_W(16)) dut (
    .clk        (clk),
    .rstn_i     (rstn),
    .start_i    (start),
    .n_cand_i   (n_cand),
    .sad_busy_i (sad_busy),
    .sad_i      (sad),
    .sad_enb_o  (sad_enb_o),
    .cand_idx_o (cand_idx_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .best_sad_o (best_sad_o),
    .best_idx_o (best_idx_o)
  );

  always #5 clk = ~clk;

  // SAD unit model: busy rises on the launch, falls after lat cycles, result then held.
  initial begin
    int          rem;
    logic [15:0] val;
    rem      = 0;
    val      = '0;
    sad_busy = 1'b0;
    sad      = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        sad_busy = 1'b0;
        rem      = 0;
      end else if (sad_enb_o) begin
        val = tbl[cand_idx_o];
        rem = lat;
        if (lat == 0) begin
          sad_busy = 1'b0;
          sad      = val;
        end else begin
          sad_busy = 1'b1;
        end
      end else if (sad_busy) begin
        rem = rem - 1;
        if (rem == 0) begin
          sad_busy = 1'b0;
          sad      = val;
        end
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input int nn);
    exp_t e;
    bit   vld;
    vld   = 1'b0;
    e.sad = '0;
    e.idx = '0;
    for (int i = 0; i < nn; i++) begin
      if (!vld || tbl[i] < e.sad) begin
        e.sad = tbl[i];
        e.idx = 6'(i);
        vld   = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic run_search(input string tag, input int n, input int l, input bit glitch);
    int   nn, cycles, enb, maxidx, wcyc;
    exp_t e;
    nn     = (n == 0) ? 64 : n;
    lat    = l;
    wcyc   = (l < 1) ? 1 : l;
    sb.push_back(model(nn));
    n_cand = 6'(n);
    start  = 1'b1;
    tick();
    cycles = 1;
    enb    = 0;
    maxidx = 0;
    while (cycles < 4000) begin
      if (sad_enb_o) enb++;
      if (int'(cand_idx_o) > maxidx) maxidx = int'(cand_idx_o);
      if (done_o) break;
      start = glitch && (cycles == 2);
      tick();
      cycles++;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, int'(done_o), 1);
    chk({tag, "_busy_in_done"}, int'(busy_o), 0);
    chk({tag, "_done_latency"}, cycles, nn * (3 + wcyc) + 1);
    chk({tag, "_launches"}, enb, nn);
    chk({tag, "_max_idx"}, maxidx, nn - 1);
    tick();
    chk({tag, "_done_pulse_width"}, int'(done_o), 0);
    if (sb.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_best_sad"}, int'(best_sad_o), int'(e.sad));
      chk({tag, "_best_idx"}, int'(best_idx_o), int'(e.idx));
    end
  endtask

  initial begin
    int enb;
    int guard;
    rstn   = 1'b0;
    start  = 1'b0;
    n_cand = '0;
    lat    = 0;
    for (int i = 0; i < 64; i++) tbl[i] = '0;
    repeat (3) tick();
    chk("rst_enb", int'(sad_enb_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_idx", int'(cand_idx_o), 0);
    chk("rst_best_sad", int'(best_sad_o), 0);
    chk("rst_best_idx", int'(best_idx_o), 0);
    rstn = 1'b1;
    tick();

    tbl[0] = 300; tbl[1] = 120; tbl[2] = 500; tbl[3] = 120;
    run_search("four", 4, 2, 1'b0);

    tbl[0] = 65280;
    run_search("single", 1, 0, 1'b0);

    for (int i = 0; i < 64; i++) tbl[i] = 16'(100 - i);
    run_search("full64", 0, 0, 1'b0);

    tbl[0] = 50; tbl[1] = 40; tbl[2] = 60;
    run_search("glitch", 3, 3, 1'b1);

    // Abort a search in candidate 2's WAIT with a small min already held.
    tbl[0] = 5; tbl[1] = 6; tbl[2] = 7; tbl[3] = 8;
    lat    = 3;
    n_cand = 6'd4;
    start  = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!(cand_idx_o == 6'd2 && !sad_enb_o && sad_busy) && guard < 200) begin
      tick();
      guard++;
    end
    chk("abort_reached_wait", guard < 200 ? 1 : 0, 1);
    rstn = 1'b0;
    #1;
    chk("abort_enb", int'(sad_enb_o), 0);
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_done", int'(done_o), 0);
    chk("abort_idx", int'(cand_idx_o), 0);
    chk("abort_best_sad", int'(best_sad_o), 0);
    chk("abort_best_idx", int'(best_idx_o), 0);
    tick();
    rstn = 1'b1;
    enb  = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (sad_enb_o) enb++;
    end
    chk("post_reset_no_launch", enb, 0);
    tbl[0] = 200; tbl[1] = 300;
    run_search("fresh", 2, 1, 1'b0);

    tbl[0] = 0; tbl[1] = 0; tbl[2] = 5;
    run_search("zero", 3, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
